fft_iter_core: RTL and testbench

//  In-place iterative radix-2 DIT FFT: one pipelined butterfly time-shared over all stages, size N=2**N_LOG2.

---
 rtl/fft_iter_core_if.sv | 29 ++
 rtl/fft_iter_core.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_fft_iter_core.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_iter_core_if.sv
// Streaming sample/bin interface for fft_iter_core.
//   s_*   : input sample stream, natural order x[0..N-1] (valid/ready handshake)
//   m_*   : output bin stream, natural order X[0..N-1], m_last marks bin N-1
// Modports:
//   master : the side that produces samples and consumes bins (framing / test logic)
//   slave  : the FFT core
interface fft_iter_core_if #(
  parameter int DW = 24
) ();
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_real;
  logic signed [DW-1:0] s_imag;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [DW-1:0] m_real;
  logic signed [DW-1:0] m_imag;
  logic                 m_last;

  modport master (
    output s_valid, s_real, s_imag, m_ready,
    input  s_ready, m_valid, m_real, m_imag, m_last
  );

  modport slave (
    input  s_valid, s_real, s_imag, m_ready,
    output s_ready, m_valid, m_real, m_imag, m_last
  );
endinterface

// File: rtl/fft_iter_core.sv
// In-place iterative radix-2 DIT FFT of size N = 2**N_LOG2 using one pipelined
// butterfly shared across all stages.
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   scale            1: halve every stage result (overall 1/N); latched on sample 0
//   io (slave)       s_valid/s_ready/s_real/s_imag input stream,
//                    m_valid/m_ready/m_real/m_imag/m_last output stream
//   tw_addr          twiddle index k into external ROM holding W_N^k
//   tw_real/tw_imag  ROM data, valid one cycle after tw_addr (1.0 == 2**(TW-3))
//   busy             high while computing (CALC/DRAIN)
//   ovf              sticky: a butterfly result saturated during this frame
// Flow: LOAD (bit-reversed store) -> per stage CALC (N/2 issues) + DRAIN (4) ->
// UNLOAD (address order) -> LOAD.
module fft_iter_core #(
  parameter int N_LOG2 = 3,
  parameter int DW     = 24,
  parameter int TW     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     scale,
  fft_iter_core_if.slave           io,
  output logic [N_LOG2-2:0]        tw_addr,
  input  logic signed [TW-1:0]     tw_real,
  input  logic signed [TW-1:0]     tw_imag,
  output logic                     busy,
  output logic                     ovf
);

  localparam int N    = 1 << N_LOG2;
  localparam int HALF = N / 2;
  localparam int AW   = N_LOG2;
  localparam int TAW  = N_LOG2 - 1;
  localparam int SW   = $clog2(N_LOG2);
  localparam int PW   = DW + TW;
  localparam int W    = DW + TW + 2;
  localparam int FRAC = TW - 3;

  localparam logic signed [W-1:0] MAXV = {{(W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {{(W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, CALC, DRAIN, UNLOAD} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic            scale_q, scale_d;
  logic            ovf_q, ovf_d;
  logic            s_ready_q, s_ready_d;

  // Data memory (no reset: contents are don't-care until loaded)
  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];

  // Butterfly pipeline registers
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [AW-1:0]        p1_q, p1_d, q1_q, q1_d;
  logic [AW-1:0]        p2_q, p2_d, q2_q, q2_d;
  logic [AW-1:0]        p3_q, p3_d, q3_q, q3_d;
  logic signed [DW-1:0] xp1_re_q, xp1_re_d, xp1_im_q, xp1_im_d;
  logic signed [DW-1:0] xq1_re_q, xq1_re_d, xq1_im_q, xq1_im_d;
  logic signed [DW-1:0] xp2_re_q, xp2_re_d, xp2_im_q, xp2_im_d;
  logic signed [PW-1:0] ac_q, ac_d, bd_q, bd_d, ad_q, ad_d, bc_q, bc_d;
  logic signed [W-1:0]  t_re_q, t_re_d, t_im_q, t_im_d;
  logic signed [W-1:0]  xs_re_q, xs_re_d, xs_im_q, xs_im_d;

  // Combinational helpers
  logic [AW-1:0]        span, k_idx, p_idx, q_idx, load_addr;
  logic                 load_we;
  logic signed [DW-1:0] yp_re, yp_im, yq_re, yq_im;
  logic                 c_pre, c_pim, c_qre, c_qim, clip_any;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // Write-back: drop twiddle fraction, optional stage halving, clamp to DW bits.
  // Returns {clamped, value}.
  function automatic logic [DW:0] wb(input logic signed [W-1:0] y, input logic sc);
    logic signed [W-1:0] s;
    s = y >>> FRAC;
    if (sc) s = s >>> 1;
    if (s > MAXV)      return {1'b1, MAXV[DW-1:0]};
    else if (s < MINV) return {1'b1, MINV[DW-1:0]};
    else               return {1'b0, s[DW-1:0]};
  endfunction

  // State register and all control/pipeline flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      stage_q   <= '0;
      scale_q   <= 1'b0;
      ovf_q     <= 1'b0;
      s_ready_q <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      p1_q      <= '0;
      q1_q      <= '0;
      p2_q      <= '0;
      q2_q      <= '0;
      p3_q      <= '0;
      q3_q      <= '0;
      xp1_re_q  <= '0;
      xp1_im_q  <= '0;
      xq1_re_q  <= '0;
      xq1_im_q  <= '0;
      xp2_re_q  <= '0;
      xp2_im_q  <= '0;
      ac_q      <= '0;
      bd_q      <= '0;
      ad_q      <= '0;
      bc_q      <= '0;
      t_re_q    <= '0;
      t_im_q    <= '0;
      xs_re_q   <= '0;
      xs_im_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      scale_q   <= scale_d;
      ovf_q     <= ovf_d;
      s_ready_q <= s_ready_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      p1_q      <= p1_d;
      q1_q      <= q1_d;
      p2_q      <= p2_d;
      q2_q      <= q2_d;
      p3_q      <= p3_d;
      q3_q      <= q3_d;
      xp1_re_q  <= xp1_re_d;
      xp1_im_q  <= xp1_im_d;
      xq1_re_q  <= xq1_re_d;
      xq1_im_q  <= xq1_im_d;
      xp2_re_q  <= xp2_re_d;
      xp2_im_q  <= xp2_im_d;
      ac_q      <= ac_d;
      bd_q      <= bd_d;
      ad_q      <= ad_d;
      bc_q      <= bc_d;
      t_re_q    <= t_re_d;
      t_im_q    <= t_im_d;
      xs_re_q   <= xs_re_d;
      xs_im_q   <= xs_im_d;
    end
  end

  // Load and butterfly writes never coincide: v3 is only set in CALC/DRAIN
  // and is cleared by reset, so a discarded frame cannot write stale data.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem_re[load_addr] <= io.s_real;
      mem_im[load_addr] <= io.s_imag;
    end
    if (v3_q) begin
      mem_re[p3_q] <= yp_re;
      mem_im[p3_q] <= yp_im;
      mem_re[q3_q] <= yq_re;
      mem_im[q3_q] <= yq_im;
    end
  end

  // Next-state / counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    scale_d = scale_q;
    ovf_d   = ovf_q;
    load_we = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (io.s_valid && s_ready_q) begin
          load_we = 1'b1;
          if (cnt_q == '0) begin
            scale_d = scale;
            ovf_d   = 1'b0;
          end
          if (cnt_q == AW'(N-1)) begin
            state_d = CALC;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CALC: begin
        if (cnt_q == AW'(HALF-1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == AW'(3)) begin
          cnt_d = '0;
          if (stage_q == SW'(N_LOG2-1)) begin
            state_d = UNLOAD;
          end else begin
            state_d = CALC;
            stage_d = stage_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UNLOAD: begin
        if (io.m_ready) begin
          if (cnt_q == AW'(N-1)) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    if (v3_q && clip_any) ovf_d = 1'b1;
    s_ready_d = (state_d == LOAD);
  end

  // Butterfly address generation and datapath
  always_comb begin
    load_addr = bitrev(cnt_q);
    span      = AW'(1) << stage_q;
    k_idx     = cnt_q & (span - AW'(1));
    // p = grp*2*span + k with grp = j >> s
    p_idx     = ((cnt_q >> stage_q) << (int'(stage_q) + 1)) | k_idx;
    q_idx     = p_idx | span;

    // c0: operand read
    v1_d     = (state_q == CALC);
    p1_d     = p_idx;
    q1_d     = q_idx;
    xp1_re_d = mem_re[p_idx];
    xp1_im_d = mem_im[p_idx];
    xq1_re_d = mem_re[q_idx];
    xq1_im_d = mem_im[q_idx];

    // c1: twiddle products
    v2_d     = v1_q;
    p2_d     = p1_q;
    q2_d     = q1_q;
    xp2_re_d = xp1_re_q;
    xp2_im_d = xp1_im_q;
    ac_d     = PW'(xq1_re_q) * PW'(tw_real);
    bd_d     = PW'(xq1_im_q) * PW'(tw_imag);
    ad_d     = PW'(xq1_re_q) * PW'(tw_imag);
    bc_d     = PW'(xq1_im_q) * PW'(tw_real);

    // c2: complex product, align xp to the twiddle fraction
    v3_d     = v2_q;
    p3_d     = p2_q;
    q3_d     = q2_q;
    t_re_d   = W'(ac_q) - W'(bd_q);
    t_im_d   = W'(ad_q) + W'(bc_q);
    xs_re_d  = W'(xp2_re_q) <<< FRAC;
    xs_im_d  = W'(xp2_im_q) <<< FRAC;

    // c3: sum/difference and write-back formatting
    {c_pre, yp_re} = wb(xs_re_q + t_re_q, scale_q);
    {c_pim, yp_im} = wb(xs_im_q + t_im_q, scale_q);
    {c_qre, yq_re} = wb(xs_re_q - t_re_q, scale_q);
    {c_qim, yq_im} = wb(xs_im_q - t_im_q, scale_q);
    clip_any = c_pre | c_pim | c_qre | c_qim;
  end

  // Outputs
  always_comb begin
    io.s_ready = s_ready_q;
    io.m_valid = (state_q == UNLOAD);
    io.m_last  = (state_q == UNLOAD) && (cnt_q == AW'(N-1));
    io.m_real  = (state_q == UNLOAD) ? mem_re[cnt_q] : '0;
    io.m_imag  = (state_q == UNLOAD) ? mem_im[cnt_q] : '0;
    busy       = (state_q == CALC) || (state_q == DRAIN);
    ovf        = ovf_q;
    tw_addr    = (state_q == CALC) ? TAW'(k_idx << (N_LOG2 - 1 - int'(stage_q))) : '0;
  end

endmodule

// File: tb/tb_fft_iter_core.sv
module tb_fft_iter_core;
  localparam int DW = 24;
  localparam int TW = 16;
  localparam real PI = 3.14159265358979;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // DUT A: N = 8
  logic                 scale_a;
  logic [1:0]           tw_addr_a;
  logic signed [TW-1:0] tw_re_a, tw_im_a;
  logic                 busy_a, ovf_a;
  fft_iter_core_if #(.DW(DW)) bus_a ();
  fft_iter_core #(.N_LOG2(3), .DW(DW), .TW(TW)) dut_a (
    .clk(clk), .rstn(rstn), .scale(scale_a), .io(bus_a.slave),
    .tw_addr(tw_addr_a), .tw_real(tw_re_a), .tw_imag(tw_im_a),
    .busy(busy_a), .ovf(ovf_a));

  // DUT B: N = 32
  logic                 scale_b;
  logic [3:0]           tw_addr_b;
  logic signed [TW-1:0] tw_re_b, tw_im_b;
  logic                 busy_b, ovf_b;
  fft_iter_core_if #(.DW(DW)) bus_b ();
  fft_iter_core #(.N_LOG2(5), .DW(DW), .TW(TW)) dut_b (
    .clk(clk), .rstn(rstn), .scale(scale_b), .io(bus_b.slave),
    .tw_addr(tw_addr_b), .tw_real(tw_re_b), .tw_imag(tw_im_b),
    .busy(busy_b), .ovf(ovf_b));

  // Twiddle ROMs, one cycle latency
  logic signed [TW-1:0] rom_re_a [4];
  logic signed [TW-1:0] rom_im_a [4];
  logic signed [TW-1:0] rom_re_b [16];
  logic signed [TW-1:0] rom_im_b [16];
  always @(posedge clk) begin
    tw_re_a <= rom_re_a[tw_addr_a];
    tw_im_a <= rom_im_a[tw_addr_a];
    tw_re_b <= rom_re_b[tw_addr_b];
    tw_im_b <= rom_im_b[tw_addr_b];
  end

  int n_assert = 0;
  int n_fail   = 0;
  int busy_cycles;

  logic signed [DW-1:0] in_re [8];
  logic signed [DW-1:0] in_im [8];
  logic signed [DW-1:0] got_re [8];
  logic signed [DW-1:0] got_im [8];
  logic signed [DW-1:0] got_b_re [32];
  logic signed [DW-1:0] got_b_im [32];

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp, input int tol);
    logic signed [63:0] d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_assert++;
    assert (!$isunknown(obs) && d <= tol) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic send_a(input logic sc);
    int g;
    bit to;
    to = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      bus_a.s_valid = 1'b1;
      bus_a.s_real  = in_re[n];
      bus_a.s_imag  = in_im[n];
      scale_a       = sc;
      g = 0;
      while (!bus_a.s_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) to = 1'b1;
    end
    @(negedge clk);
    bus_a.s_valid = 1'b0;
    check("send_timeout", to, 0);
  endtask

  task automatic recv_a(input bit stall, input logic exp_ovf);
    int g, idx;
    bit held, rdy;
    logic signed [DW-1:0] h_re, h_im;
    logic h_last;
    busy_cycles = 0;
    g = 0;
    while (!bus_a.m_valid && g < 200) begin
      if (busy_a) busy_cycles++;
      @(negedge clk);
      g++;
    end
    check("m_valid_timeout", (g < 200), 1);
    check("ovf_in_unload", ovf_a, exp_ovf);
    idx = 0; held = 1'b0; g = 0;
    h_re = '0; h_im = '0; h_last = 1'b0;
    while (idx < 8 && g < 400) begin
      if (held) begin
        check("stall_re", bus_a.m_real, h_re);
        check("stall_im", bus_a.m_imag, h_im);
        check("stall_last", bus_a.m_last, h_last);
      end
      check("m_valid_unload", bus_a.m_valid, 1);
      check("s_ready_unload", bus_a.s_ready, 0);
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus_a.m_ready = rdy;
      if (rdy) begin
        got_re[idx] = bus_a.m_real;
        got_im[idx] = bus_a.m_imag;
        check($sformatf("m_last_bin%0d", idx), bus_a.m_last, (idx == 7));
        idx++;
        held = 1'b0;
      end else begin
        held   = 1'b1;
        h_re   = bus_a.m_real;
        h_im   = bus_a.m_imag;
        h_last = bus_a.m_last;
      end
      @(negedge clk);
      g++;
    end
    bus_a.m_ready = 1'b0;
    check("unload_count", idx, 8);
    check("s_ready_after_unload", bus_a.s_ready, 1);
    check("m_valid_after_unload", bus_a.m_valid, 0);
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_s_ready"}, bus_a.s_ready, 0);
    check({pfx, "_m_valid"}, bus_a.m_valid, 0);
    check({pfx, "_m_last"}, bus_a.m_last, 0);
    check({pfx, "_m_real"}, bus_a.m_real, 0);
    check({pfx, "_m_imag"}, bus_a.m_imag, 0);
    check({pfx, "_busy"}, busy_a, 0);
    check({pfx, "_ovf"}, ovf_a, 0);
    check({pfx, "_tw_addr"}, tw_addr_a, 0);
  endtask

  task automatic set_impulse();
    for (int n = 0; n < 8; n++) begin
      in_re[n] = (n == 0) ? 24'sd1000 : 24'sd0;
      in_im[n] = '0;
    end
  endtask

  task automatic check_impulse(input string pfx);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_X%0d_re", pfx, k), got_re[k], 1000);
      check($sformatf("%s_X%0d_im", pfx, k), got_im[k], 0);
    end
  endtask

  initial begin
    int g;
    for (int k = 0; k < 4; k++) begin
      rom_re_a[k] = 16'($rtoi($floor(8192.0 * $cos(2.0 * PI * k / 8.0) + 0.5)));
      rom_im_a[k] = 16'($rtoi($floor(-8192.0 * $sin(2.0 * PI * k / 8.0) + 0.5)));
    end
    for (int k = 0; k < 16; k++) begin
      rom_re_b[k] = 16'($rtoi($floor(8192.0 * $cos(2.0 * PI * k / 32.0) + 0.5)));
      rom_im_b[k] = 16'($rtoi($floor(-8192.0 * $sin(2.0 * PI * k / 32.0) + 0.5)));
    end
    rstn = 1'b0;
    scale_a = 1'b0; scale_b = 1'b0;
    bus_a.s_valid = 1'b0; bus_a.s_real = '0; bus_a.s_imag = '0; bus_a.m_ready = 1'b0;
    bus_b.s_valid = 1'b0; bus_b.s_real = '0; bus_b.s_imag = '0; bus_b.m_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_outputs_zero("rst");
    rstn = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", bus_a.s_ready, 1);
    check("busy_after_rst", busy_a, 0);

    // Impulse, scale=0
    set_impulse();
    send_a(1'b0);
    recv_a(1'b0, 1'b0);
    check_impulse("imp");
    check("imp_busy_cycles", busy_cycles, 24);
    check("imp_ovf", ovf_a, 0);

    // DC, scale=0
    for (int n = 0; n < 8; n++) begin in_re[n] = 24'sd1000; in_im[n] = '0; end
    send_a(1'b0);
    recv_a(1'b0, 1'b0);
    check_near("dc_X0_re", got_re[0], 8000, 2);
    check_near("dc_X0_im", got_im[0], 0, 2);
    for (int k = 1; k < 8; k++) begin
      check_near($sformatf("dc_X%0d_re", k), got_re[k], 0, 2);
      check_near($sformatf("dc_X%0d_im", k), got_im[k], 0, 2);
    end

    // DC, scale=1
    send_a(1'b1);
    recv_a(1'b0, 1'b0);
    check_near("dcs_X0_re", got_re[0], 1000, 2);
    check_near("dcs_X3_re", got_re[3], 0, 2);

    // Tone at bin 1
    in_re[0] = 24'sd4096;  in_im[0] = 24'sd0;
    in_re[1] = 24'sd2896;  in_im[1] = 24'sd2896;
    in_re[2] = 24'sd0;     in_im[2] = 24'sd4096;
    in_re[3] = -24'sd2896; in_im[3] = 24'sd2896;
    in_re[4] = -24'sd4096; in_im[4] = 24'sd0;
    in_re[5] = -24'sd2896; in_im[5] = -24'sd2896;
    in_re[6] = 24'sd0;     in_im[6] = -24'sd4096;
    in_re[7] = 24'sd2896;  in_im[7] = -24'sd2896;
    send_a(1'b0);
    recv_a(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check_near($sformatf("tone_X%0d_re", k), got_re[k], (k == 1) ? 32768 : 0, 8);
      check_near($sformatf("tone_X%0d_im", k), got_im[k], 0, 8);
    end

    // Full-scale real, scale=0: saturation
    for (int n = 0; n < 8; n++) begin in_re[n] = 24'sh7FFFFF; in_im[n] = '0; end
    send_a(1'b0);
    recv_a(1'b0, 1'b1);
    check("sat_X0_re", got_re[0], 8388607);
    check("sat_ovf_hold", ovf_a, 1);

    // Full-scale real, scale=1: no saturation, ovf cleared on new frame
    send_a(1'b1);
    check("sat_ovf_cleared", ovf_a, 0);
    recv_a(1'b0, 1'b0);
    check_near("scl_X0_re", got_re[0], 8388607, 3);
    check("scl_ovf", ovf_a, 0);

    // Impulse with random backpressure
    set_impulse();
    send_a(1'b0);
    recv_a(1'b1, 1'b0);
    check_impulse("stl");
    check("stl_busy_cycles", busy_cycles, 24);

    // Reset pulsed mid-CALC of a saturating frame
    for (int n = 0; n < 8; n++) begin in_re[n] = 24'sh7FFFFF; in_im[n] = '0; end
    send_a(1'b0);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", busy_a, 1);
    check("pre_rst_ovf", ovf_a, 1);
    rstn = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    check_outputs_zero("midrst2");
    rstn = 1'b1;
    @(negedge clk);
    check("s_ready_after_midrst", bus_a.s_ready, 1);
    set_impulse();
    send_a(1'b0);
    recv_a(1'b0, 1'b0);
    check_impulse("post");

    // N=32 DC regression
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      bus_b.s_valid = 1'b1;
      bus_b.s_real  = 24'sd1000;
      bus_b.s_imag  = '0;
      g = 0;
      while (!bus_b.s_ready && g < 100) begin @(negedge clk); g++; end
    end
    @(negedge clk);
    bus_b.s_valid = 1'b0;
    g = 0;
    while (!bus_b.m_valid && g < 500) begin @(negedge clk); g++; end
    check("b_m_valid_timeout", (g < 500), 1);
    for (int k = 0; k < 32; k++) begin
      bus_b.m_ready = 1'b1;
      got_b_re[k] = bus_b.m_real;
      got_b_im[k] = bus_b.m_imag;
      @(negedge clk);
    end
    bus_b.m_ready = 1'b0;
    check_near("b_X0_re", got_b_re[0], 32000, 2);
    check_near("b_X0_im", got_b_im[0], 0, 2);
    for (int k = 1; k < 32; k++) check_near($sformatf("b_X%0d_re", k), got_b_re[k], 0, 2);
    check("b_ovf", ovf_b, 0);
    check("b_s_ready_after", bus_b.s_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
